// File: rtl/axi4l_gpio_pkg.sv
// Shared definitions for the AXI4-Lite GPIO slave: register offsets,
// response codes, bus FSM states and a byte-strobe expansion helper.
package axi4l_gpio_pkg;

    // Byte offsets of the registers; only addr[4:2] takes part in decoding.
    localparam logic [4:0] GPIO_OUT        = 5'h00;
    localparam logic [4:0] GPIO_IN         = 5'h04;
    localparam logic [4:0] GPIO_IRQ_EN     = 5'h08;
    localparam logic [4:0] GPIO_IRQ_STATUS = 5'h0C;
    localparam logic [4:0] GPIO_OUT_SET    = 5'h10;
    localparam logic [4:0] GPIO_OUT_CLR    = 5'h14;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Width of the per-bit debounce counter; covers DEBOUNCE up to 65535.
    localparam int unsigned DEB_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRESP = 2'd1,
        RRESP = 2'd2
    } gpio_state_e;

    // Expand the 4-bit write strobe into a 32-bit bit mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/axi4l_if.sv
// AXI4-Lite bus bundle, 32-bit address and data.
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both high; a source holds valid and its payload stable until that edge.
interface axi4l_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/gpio_debounce.sv
// One input bit: 2-flop synchroniser, stability counter and debounced value.
// rise pulses on the same edge that the debounced value goes 0 -> 1.
module gpio_debounce
    import axi4l_gpio_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    // The counter accepts the new value on the cycle it would reach DEBOUNCE.
    localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEBOUNCE - 1);

    logic                 meta_q, meta_d;
    logic                 sync_q, sync_d;
    logic                 deb_q, deb_d;
    logic [DEB_CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: shift the synchroniser, count disagreement, accept when stable.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
        deb_d  = deb_q;
        cnt_d  = cnt_q;
        if (sync_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
            deb_d = sync_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            deb_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            deb_q  <= deb_d;
            cnt_q  <= cnt_d;
        end
    end

    assign q    = deb_q;
    assign rise = deb_d & ~deb_q;

endmodule

// File: rtl/axi4l_gpio.sv
// AXI4-Lite GPIO slave: OUT with atomic set/clear, debounced IN,
// rising-edge IRQ_STATUS with enable mask and a registered level interrupt.
module axi4l_gpio
    import axi4l_gpio_pkg::*;
#(
    parameter int unsigned     NOUT      = 4,
    parameter int unsigned     NIN       = 8,
    parameter logic [NOUT-1:0] OUT_RESET = '0,
    parameter int unsigned     DEBOUNCE  = 16
) (
    input  logic            clk,
    input  logic            rst,
    axi4l_if.slave          axi,
    output logic [NOUT-1:0] gpio_o,
    input  logic [NIN-1:0]  gpio_i,
    output logic            irq
);

    gpio_state_e     state_q, state_d;
    logic [NOUT-1:0] out_q, out_d;
    logic [NIN-1:0]  irq_en_q, irq_en_d;
    logic [NIN-1:0]  irq_sts_q, irq_sts_d;
    logic            irq_q, irq_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [1:0]      rresp_q, rresp_d;
    logic [1:0]      bresp_q, bresp_d;

    logic            wr_hs;
    logic            rd_hs;
    logic [4:0]      wr_off;
    logic [4:0]      rd_off;
    logic [31:0]     wmask;
    logic [31:0]     wbits;
    logic [NIN-1:0]  sts_clr;
    logic [NIN-1:0]  in_deb;
    logic [NIN-1:0]  in_rise;
    logic            unused_bits;

    // One debounce cell per input bit.
    for (genvar i = 0; i < NIN; i++) begin : g_deb
        gpio_debounce #(
            .DEBOUNCE(DEBOUNCE)
        ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .d    (gpio_i[i]),
            .q    (in_deb[i]),
            .rise (in_rise[i])
        );
    end

    // Only addr[4:2] selects a register; the interconnect decodes the base.
    assign wr_off = {axi.awaddr[4:2], 2'b00};
    assign rd_off = {axi.araddr[4:2], 2'b00};
    assign wmask  = strb_mask(axi.wstrb);
    assign wbits  = axi.wdata & wmask;

    // Bus FSM: a complete AW+W pair wins over AR; one transaction at a time.
    always_comb begin
        state_d = state_q;
        wr_hs   = 1'b0;
        rd_hs   = 1'b0;
        case (state_q)
            IDLE: begin
                if (axi.awvalid && axi.wvalid) begin
                    wr_hs   = 1'b1;
                    state_d = WRESP;
                end else if (axi.arvalid) begin
                    rd_hs   = 1'b1;
                    state_d = RRESP;
                end
            end
            WRESP: begin
                if (axi.bready) begin
                    state_d = IDLE;
                end
            end
            RRESP: begin
                if (axi.rready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register writes on the AW/W handshake; strobe-masked bits stay unchanged.
    always_comb begin
        out_d    = out_q;
        irq_en_d = irq_en_q;
        sts_clr  = '0;
        bresp_d  = bresp_q;
        if (wr_hs) begin
            bresp_d = RESP_OKAY;
            case (wr_off)
                GPIO_OUT:        out_d    = (out_q & ~wmask[NOUT-1:0]) | wbits[NOUT-1:0];
                GPIO_IN:         out_d    = out_q;
                GPIO_IRQ_EN:     irq_en_d = (irq_en_q & ~wmask[NIN-1:0]) | wbits[NIN-1:0];
                GPIO_IRQ_STATUS: sts_clr  = wbits[NIN-1:0];
                GPIO_OUT_SET:    out_d    = out_q | wbits[NOUT-1:0];
                GPIO_OUT_CLR:    out_d    = out_q & ~wbits[NOUT-1:0];
                default:         bresp_d  = RESP_SLVERR;
            endcase
        end
    end

    // Edge capture wins over a simultaneous write-1-to-clear; irq is the
    // registered OR of enabled status bits.
    always_comb begin
        irq_sts_d = (irq_sts_q & ~sts_clr) | in_rise;
        irq_d     = |(irq_sts_q & irq_en_q);
    end

    // Read data captured on the AR handshake; write-only offsets read as 0.
    always_comb begin
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        if (rd_hs) begin
            rdata_d = '0;
            rresp_d = RESP_OKAY;
            case (rd_off)
                GPIO_OUT:        rdata_d[NOUT-1:0] = out_q;
                GPIO_IN:         rdata_d[NIN-1:0]  = in_deb;
                GPIO_IRQ_EN:     rdata_d[NIN-1:0]  = irq_en_q;
                GPIO_IRQ_STATUS: rdata_d[NIN-1:0]  = irq_sts_q;
                GPIO_OUT_SET:    rdata_d           = '0;
                GPIO_OUT_CLR:    rdata_d           = '0;
                default:         rresp_d           = RESP_SLVERR;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            out_q     <= OUT_RESET;
            irq_en_q  <= '0;
            irq_sts_q <= '0;
            irq_q     <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            bresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            irq_en_q  <= irq_en_d;
            irq_sts_q <= irq_sts_d;
            irq_q     <= irq_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            bresp_q   <= bresp_d;
        end
    end

    assign axi.awready = wr_hs;
    assign axi.wready  = wr_hs;
    assign axi.arready = rd_hs;
    assign axi.bvalid  = (state_q == WRESP);
    assign axi.rvalid  = (state_q == RRESP);
    assign axi.bresp   = bresp_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;
    assign gpio_o      = out_q;
    assign irq         = irq_q;

    // Address bits outside [4:2] and data bits above the register widths are ignored.
    assign unused_bits = ^{axi.awaddr[31:5], axi.awaddr[1:0],
                           axi.araddr[31:5], axi.araddr[1:0], wbits, wmask};

endmodule

// File: tb/tb_axi4l_gpio.sv
// Self-checking bench for axi4l_gpio (NOUT=4, NIN=8, OUT_RESET=4'hA, DEBOUNCE=4).
module tb_axi4l_gpio;

    logic       clk;
    logic       rst;
    logic [3:0] gpio_o;
    logic [7:0] gpio_i;
    logic       irq;

    int n_vec = 0;
    int n_err = 0;

    axi4l_if bus ();

    axi4l_gpio #(
        .NOUT      (4),
        .NIN       (8),
        .OUT_RESET (4'hA),
        .DEBOUNCE  (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .axi    (bus),
        .gpio_o (gpio_o),
        .gpio_i (gpio_i),
        .irq    (irq)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    // Entry: {resp[1:0], rdata[31:0], gpio[3:0]}
    logic [37:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp);
        int n;
        bus.awaddr  = a;
        bus.wdata   = d;
        bus.wstrb   = s;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.awready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.awready) check("aw_handshake_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.bvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.bvalid) check("b_timeout", 32'd0, 32'd1);
        resp = bus.bresp;
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.arready) check("ar_handshake_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.arvalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.rvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rvalid) check("r_timeout", 32'd0, 32'd1);
        d    = bus.rdata;
        resp = bus.rresp;
        @(posedge clk);
        #1;
    endtask

    task automatic read_check(input string name, input logic [31:0] a,
                              input logic [31:0] exp_d, input logic [1:0] exp_r);
        logic [31:0] d;
        logic [1:0]  r;
        do_read(a, d, r);
        check({name, "_data"}, d, exp_d);
        check({name, "_resp"}, 32'(r), 32'(exp_r));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        logic [3:0]  exp_gpio;
    } vec_t;

    localparam int NV = 23;
    vec_t vt[NV];

    initial begin
        logic [31:0] rd;
        logic [1:0]  rr;
        logic [37:0] e;

        vt[0]  = '{1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'h0000_000A, 2'b00, 4'hA};
        vt[1]  = '{1'b1, 32'h0000_0010, 32'h3, 4'hF, 32'h0, 2'b00, 4'hB};
        vt[2]  = '{1'b1, 32'h0000_0014, 32'h8, 4'hF, 32'h0, 2'b00, 4'h3};
        vt[3]  = '{1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h0, 2'b00, 4'h3};
        vt[4]  = '{1'b1, 32'h0000_0000, 32'h5, 4'h0, 32'h0, 2'b00, 4'h3};
        vt[5]  = '{1'b0, 32'h0000_0014, 32'h0, 4'h0, 32'h0, 2'b00, 4'h3};
        vt[6]  = '{1'b1, 32'h0000_0000, 32'hFFFF_FFF6, 4'h1, 32'h0, 2'b00, 4'h6};
        vt[7]  = '{1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'h0000_0006, 2'b00, 4'h6};
        vt[8]  = '{1'b0, 32'h0000_0018, 32'h0, 4'h0, 32'h0, 2'b10, 4'h6};
        vt[9]  = '{1'b1, 32'h0000_001C, 32'hF, 4'hF, 32'h0, 2'b10, 4'h6};
        vt[10] = '{1'b1, 32'h0000_0008, 32'hFF, 4'hE, 32'h0, 2'b00, 4'h6};
        vt[11] = '{1'b0, 32'h0000_0008, 32'h0, 4'h0, 32'h0, 2'b00, 4'h6};
        vt[12] = '{1'b1, 32'h0000_0008, 32'h101, 4'h1, 32'h0, 2'b00, 4'h6};
        vt[13] = '{1'b0, 32'h0000_0008, 32'h0, 4'h0, 32'h0000_0001, 2'b00, 4'h6};
        vt[14] = '{1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'h0000_0006, 2'b00, 4'h6};
        vt[15] = '{1'b0, 32'h0000_000C, 32'h0, 4'h0, 32'h0, 2'b00, 4'h6};
        vt[16] = '{1'b1, 32'h0000_0004, 32'hFF, 4'hF, 32'h0, 2'b00, 4'h6};
        vt[17] = '{1'b0, 32'h0000_0004, 32'h0, 4'h0, 32'h0, 2'b00, 4'h6};
        vt[18] = '{1'b0, 32'h0000_001C, 32'h0, 4'h0, 32'h0, 2'b10, 4'h6};
        vt[19] = '{1'b1, 32'h0000_0010, 32'h10, 4'hF, 32'h0, 2'b00, 4'h6};
        vt[20] = '{1'b1, 32'h0000_0010, 32'hF, 4'h0, 32'h0, 2'b00, 4'h6};
        vt[21] = '{1'b1, 32'h0000_0014, 32'h2, 4'hF, 32'h0, 2'b00, 4'h4};
        vt[22] = '{1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'h0000_0004, 2'b00, 4'h4};

        bus.awaddr  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b1;
        bus.araddr  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        gpio_i      = '0;
        rst         = 1'b1;

        // ---- reset ----
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_gpio_o", 32'(gpio_o), 32'hA);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_bvalid", 32'(bus.bvalid), 32'h0);
        check("rst_rvalid", 32'(bus.rvalid), 32'h0);
        check("rst_awready", 32'(bus.awready), 32'h0);
        check("rst_arready", 32'(bus.arready), 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_bresp", 32'(bus.bresp), 32'h0);
        check("rst_rresp", 32'(bus.rresp), 32'h0);

        // ---- table-driven register accesses ----
        for (int i = 0; i < NV; i++) begin
            exp_q.push_back({vt[i].exp_resp, vt[i].exp_rdata, vt[i].exp_gpio});
            if (vt[i].wr) begin
                do_write(vt[i].addr, vt[i].data, vt[i].strb, rr);
                rd = '0;
            end else begin
                do_read(vt[i].addr, rd, rr);
            end
            e = exp_q.pop_front();
            check($sformatf("vec%0d_resp", i), 32'(rr), 32'(e[37:36]));
            if (!vt[i].wr) check($sformatf("vec%0d_rdata", i), rd, e[35:4]);
            check($sformatf("vec%0d_gpio_o", i), 32'(gpio_o), 32'(e[3:0]));
        end

        // ---- debounce: 3-cycle glitch is rejected ----
        gpio_i[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        gpio_i[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        read_check("glitch_in", 32'h4, 32'h0, 2'b00);
        read_check("glitch_sts", 32'hC, 32'h0, 2'b00);
        check("glitch_irq", 32'(irq), 32'h0);

        // ---- debounce: held input reaches IN 6 cycles after change, irq 1 later ----
        gpio_i[0] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("hold_irq_e5", 32'(irq), 32'h0);
        bus.araddr  = 32'h4;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b0;
        @(negedge clk);
        check("hold_arready_e6", 32'(bus.arready), 32'h1);
        @(posedge clk);
        #1;
        bus.arvalid = 1'b0;
        check("hold_rvalid", 32'(bus.rvalid), 32'h1);
        check("hold_in_before_e6", bus.rdata, 32'h0);
        check("hold_irq_e6", 32'(irq), 32'h0);
        @(posedge clk);
        #1;
        check("hold_irq_e7", 32'(irq), 32'h1);
        bus.rready = 1'b1;
        @(posedge clk);
        #1;
        read_check("hold_in", 32'h4, 32'h1, 2'b00);
        read_check("hold_sts", 32'hC, 32'h1, 2'b00);

        // ---- W1C on the same edge as a new rising edge: set wins ----
        gpio_i[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        gpio_i[0] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.awaddr  = 32'hC;
        bus.wdata   = 32'h1;
        bus.wstrb   = 4'hF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b1;
        @(negedge clk);
        check("coll_awready", 32'(bus.awready), 32'h1);
        @(posedge clk);
        #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check("coll_bvalid", 32'(bus.bvalid), 32'h1);
        @(posedge clk);
        #1;
        read_check("coll_sts", 32'hC, 32'h1, 2'b00);
        check("coll_irq", 32'(irq), 32'h1);

        // ---- later W1C clears; irq falls one cycle after the clear ----
        bus.awaddr  = 32'hC;
        bus.wdata   = 32'h1;
        bus.wstrb   = 4'hF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        @(negedge clk);
        check("clr_awready", 32'(bus.awready), 32'h1);
        @(posedge clk);
        #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check("clr_irq_at_edge", 32'(irq), 32'h1);
        @(posedge clk);
        #1;
        check("clr_irq_next", 32'(irq), 32'h0);
        read_check("clr_sts", 32'hC, 32'h0, 2'b00);

        // ---- simultaneous write and read: write first ----
        bus.awaddr  = 32'h0;
        bus.wdata   = 32'h5;
        bus.wstrb   = 4'hF;
        bus.araddr  = 32'h0;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.arvalid = 1'b1;
        @(negedge clk);
        check("both_awready", 32'(bus.awready), 32'h1);
        check("both_arready_blocked", 32'(bus.arready), 32'h0);
        @(posedge clk);
        #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check("both_bvalid", 32'(bus.bvalid), 32'h1);
        check("both_arready_wresp", 32'(bus.arready), 32'h0);
        @(posedge clk);
        #1;
        check("both_arready_idle", 32'(bus.arready), 32'h1);
        @(posedge clk);
        #1;
        bus.arvalid = 1'b0;
        exp_q.push_back({2'b00, 32'h5, 4'h5});
        e = exp_q.pop_front();
        check("both_rvalid", 32'(bus.rvalid), 32'h1);
        check("both_rdata", bus.rdata, e[35:4]);
        check("both_gpio_o", 32'(gpio_o), 32'(e[3:0]));
        @(posedge clk);
        #1;

        // ---- bready held low: bvalid holds, no new handshake ----
        bus.awaddr  = 32'h0;
        bus.wdata   = 32'h9;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b0;
        @(negedge clk);
        check("bp_awready", 32'(bus.awready), 32'h1);
        @(posedge clk);
        #1;
        bus.awaddr = 32'h10;
        bus.wdata  = 32'h2;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp_bvalid_%0d", k), 32'(bus.bvalid), 32'h1);
            check($sformatf("bp_awready_%0d", k), 32'(bus.awready), 32'h0);
            check($sformatf("bp_gpio_o_%0d", k), 32'(gpio_o), 32'h9);
        end
        @(posedge clk);
        #1;
        bus.bready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_second_awready", 32'(bus.awready), 32'h1);
        @(posedge clk);
        #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check("bp_second_gpio_o", 32'(gpio_o), 32'hB);
        @(posedge clk);
        #1;

        // ---- reset while rvalid is pending ----
        bus.araddr  = 32'h0;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        bus.arvalid = 1'b0;
        check("rr_rvalid_pending", 32'(bus.rvalid), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rr_rvalid_dropped", 32'(bus.rvalid), 32'h0);
        check("rr_gpio_o", 32'(gpio_o), 32'hA);
        bus.rready = 1'b1;
        read_check("rr_next_read", 32'h0, 32'hA, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
